// File: rtl/spart_mask_queue.sv
// rtl/spart_mask_queue.sv - first-word-fall-through queue for SPART bit masks
// Optional drop counter port ovf_cnt enabled by defining MASK_QUEUE_OVF_CNT_EN.
module spart_mask_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0]                 bit_mask,
  input  logic                       bit_mask_ready,
  output logic [4:0]                 mask_out,
  output logic                       mask_valid,
  input  logic                       mask_ack,
  output logic [4:0]                 mask_held,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
`ifdef MASK_QUEUE_OVF_CNT_EN
  output logic [7:0]                 ovf_cnt,
`endif
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  assign mask_valid = (cnt != '0);
  assign full       = (cnt == CW'(DEPTH));
  assign pop        = mask_valid && mask_ack;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push       = bit_mask_ready && (!full || pop);
  assign drop       = bit_mask_ready && !push;
  assign mask_out   = mask_valid ? mem[rd_ptr] : 5'b0;
  assign count      = cnt;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= bit_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      mask_held <= 5'b0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + AW'(1);
        mask_held <= bit_mask;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // A drop in the same cycle as ovf_clr leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

`ifdef MASK_QUEUE_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= 8'd0;
    end else if (ovf_clr) begin
      ovf_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`endif

endmodule
